// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage
//  Purpose  : Write-back stage of the multi-cycle CPU. Accepts one retiring
//             instruction at a time, waits for memory read data on loads,
//             extracts/extends the addressed byte or halfword, and commits
//             the result through the register file's single write port.
//  Ports    :
//    clk, rst                 clock, synchronous active-high reset
//    in_valid / in_ready      upstream handshake for a retiring instruction
//    in_rd, in_is_load,
//    in_load_type, in_addr_lo,
//    in_result                instruction fields captured on accept
//    mem_rdata_valid/_ready   load read-data handshake
//    mem_rdata                raw memory word
//    rf_wen, rf_waddr,
//    rf_wdata                 register-file write port (rf_wen is a pulse)
//    wb_done                  one-cycle retire pulse (also for rd = x0)
//  Optional : `WB_PERF_CNT_EN adds retired_cnt and load_stall_cnt outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_is_load,
  input  logic [2:0]            in_load_type,
  input  logic [1:0]            in_addr_lo,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  mem_rdata_valid,
  output logic                  mem_rdata_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  wb_done
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]           retired_cnt,
  output logic [31:0]           load_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_COMMIT   = 2'd2
  } state_t;

  localparam logic [2:0] C_LT_LB  = 3'b000;
  localparam logic [2:0] C_LT_LH  = 3'b001;
  localparam logic [2:0] C_LT_LBU = 3'b100;
  localparam logic [2:0] C_LT_LHU = 3'b101;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_rd;
  logic [2:0]            r_load_type;
  logic [1:0]            r_addr_lo;

  logic                  w_accept;
  logic                  w_mem_accept;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load_data;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    in_ready        = 1'b0;
    mem_rdata_ready = 1'b0;
    rf_wen          = 1'b0;
    wb_done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = in_is_load ? S_WAIT_MEM : S_COMMIT;
        end
      end
      S_WAIT_MEM: begin
        mem_rdata_ready = 1'b1;
        if (mem_rdata_valid) begin
          w_state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        // x0 is hardwired to zero, so its write pulse is suppressed while
        // the instruction still retires.
        rf_wen      = (r_rd != '0);
        wb_done     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_accept     = in_valid & in_ready;
  assign w_mem_accept = mem_rdata_valid & mem_rdata_ready;

  // --------------------------------------------------------------------------
  // Load lane extraction. Halfword lane uses addr_lo[1] only.
  // --------------------------------------------------------------------------
  assign w_byte = mem_rdata[{r_addr_lo, 3'b000} +: 8];
  assign w_half = mem_rdata[{r_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    w_load_data = mem_rdata;
    case (r_load_type)
      C_LT_LB:  w_load_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      C_LT_LBU: w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      C_LT_LH:  w_load_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      C_LT_LHU: w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default:  w_load_data = mem_rdata;
    endcase
  end

  // --------------------------------------------------------------------------
  // Captured fields and registered write port. rf_waddr/rf_wdata only change
  // on the edge entering COMMIT so they hold the last committed values while
  // a load is waiting. The is_load flag and ALU result need no later storage:
  // the state encodes the former and rf_wdata holds the latter.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd        <= '0;
      r_load_type <= '0;
      r_addr_lo   <= '0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
    end else begin
      if (w_accept) begin
        r_rd        <= in_rd;
        r_load_type <= in_load_type;
        r_addr_lo   <= in_addr_lo;
        if (!in_is_load) begin
          rf_waddr <= in_rd;
          rf_wdata <= in_result;
        end
      end
      if (w_mem_accept) begin
        rf_waddr <= r_rd;
        rf_wdata <= w_load_data;
      end
    end
  end

`ifdef WB_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Performance counters (free-running, wrap naturally)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt    <= '0;
      load_stall_cnt <= '0;
    end else begin
      if (wb_done) begin
        retired_cnt <= retired_cnt + 32'd1;
      end
      if (r_state == S_WAIT_MEM) begin
        load_stall_cnt <= load_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_stage
//  Purpose  : Directed self-checking bench for wb_stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_is_load;
  logic [2:0]  in_load_type;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_result;
  logic        mem_rdata_valid;
  logic        mem_rdata_ready;
  logic [31:0] mem_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_done;
`ifdef WB_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] load_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  wb_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_rd           (in_rd),
    .in_is_load      (in_is_load),
    .in_load_type    (in_load_type),
    .in_addr_lo      (in_addr_lo),
    .in_result       (in_result),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata_ready (mem_rdata_ready),
    .mem_rdata       (mem_rdata),
    .rf_wen          (rf_wen),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .wb_done         (wb_done)
`ifdef WB_PERF_CNT_EN
    ,
    .retired_cnt     (retired_cnt),
    .load_stall_cnt  (load_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one load through the stage, checking the wait and commit cycles.
  task automatic run_load(input string tag, input logic [4:0] rd, input logic [2:0] lt,
                          input logic [1:0] lo, input logic [31:0] word,
                          input logic [31:0] exp_data);
    in_valid = 1'b1; in_is_load = 1'b1; in_rd = rd; in_load_type = lt; in_addr_lo = lo;
    step();
    in_valid = 1'b0;
    check({tag, "_wait_ready"}, {31'd0, mem_rdata_ready}, 32'd1);
    mem_rdata_valid = 1'b1; mem_rdata = word;
    step();
    mem_rdata_valid = 1'b0; mem_rdata = 32'hBAD0BAD0;
    check({tag, "_wdata"}, rf_wdata, exp_data);
    check({tag, "_wen"}, {31'd0, rf_wen}, (rd != 5'd0) ? 32'd1 : 32'd0);
    check({tag, "_done"}, {31'd0, wb_done}, 32'd1);
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_rd = 5'd3; in_is_load = 1'b0;
    in_load_type = 3'd0; in_addr_lo = 2'd0; in_result = 32'hAAAA5555;
    mem_rdata_valid = 1'b0; mem_rdata = 32'h0;

    // Reset held two cycles with in_valid asserted: nothing accepted.
    step();
    step();
    check("rst_wen", {31'd0, rf_wen}, 32'd0);
    check("rst_done", {31'd0, wb_done}, 32'd0);
    check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    step();
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_no_accept", {31'd0, wb_done}, 32'd0);

    // ALU write.
    in_valid = 1'b1; in_rd = 5'd5; in_is_load = 1'b0; in_result = 32'hDEADBEEF;
    step();
    check("alu_wen", {31'd0, rf_wen}, 32'd1);
    check("alu_waddr", {27'd0, rf_waddr}, 32'd5);
    check("alu_wdata", rf_wdata, 32'hDEADBEEF);
    check("alu_done", {31'd0, wb_done}, 32'd1);
    check("alu_ready", {31'd0, in_ready}, 32'd0);
    // in_valid held through COMMIT with new fields: not accepted there.
    in_rd = 5'd6; in_result = 32'h00000001;
    step();
    in_valid = 1'b0;
    check("alu_after_ready", {31'd0, in_ready}, 32'd1);
    check("alu_after_wen", {31'd0, rf_wen}, 32'd0);
    check("alu_after_done", {31'd0, wb_done}, 32'd0);
    check("alu_hold_waddr", {27'd0, rf_waddr}, 32'd5);
    check("alu_hold_wdata", rf_wdata, 32'hDEADBEEF);

    // x0 suppression.
    in_valid = 1'b1; in_rd = 5'd0; in_result = 32'h12345678;
    step();
    in_valid = 1'b0;
    check("x0_done", {31'd0, wb_done}, 32'd1);
    check("x0_wen", {31'd0, rf_wen}, 32'd0);
    step();
    check("x0_after_wen", {31'd0, rf_wen}, 32'd0);

    // LB sign extend with 3-cycle read delay; stray mem valid in IDLE ignored.
    in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd7; in_load_type = 3'b000; in_addr_lo = 2'd3;
    mem_rdata_valid = 1'b1; mem_rdata = 32'h11111111;
    step();
    in_valid = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = 32'h22222222;
    for (int i = 0; i < 3; i++) begin
      check("lb_wait_ready", {31'd0, mem_rdata_ready}, 32'd1);
      check("lb_wait_done", {31'd0, wb_done}, 32'd0);
      step();
    end
    check("lb_in_ready", {31'd0, in_ready}, 32'd0);
    mem_rdata_valid = 1'b1; mem_rdata = 32'h80FF1234;
    step();
    mem_rdata_valid = 1'b0;
    check("lb_wdata", rf_wdata, 32'hFFFFFF80);
    check("lb_wen", {31'd0, rf_wen}, 32'd1);
    check("lb_waddr", {27'd0, rf_waddr}, 32'd7);
    check("lb_mem_ready", {31'd0, mem_rdata_ready}, 32'd0);
    step();

    // Other load types on the same word.
    run_load("lhu2", 5'd8,  3'b101, 2'd2, 32'h80FF1234, 32'h000080FF);
    run_load("lbu1", 5'd8,  3'b100, 2'd1, 32'h80FF1234, 32'h00000012);
    run_load("lw3",  5'd8,  3'b010, 2'd3, 32'h80FF1234, 32'h80FF1234);
    run_load("lh0",  5'd11, 3'b001, 2'd1, 32'h80FF1234, 32'h00001234);
    run_load("lh2",  5'd12, 3'b001, 2'd3, 32'h80FF1234, 32'hFFFF80FF);
    run_load("lb0",  5'd13, 3'b000, 2'd0, 32'h80FF12F4, 32'hFFFFFFF4);
    run_load("bad3", 5'd14, 3'b011, 2'd1, 32'hCAFEF00D, 32'hCAFEF00D);
    run_load("ldx0", 5'd0,  3'b010, 2'd0, 32'h0BADCAFE, 32'h0BADCAFE);

    // Reset mid-load abandons the instruction.
    in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd9; in_load_type = 3'b010;
    step();
    in_valid = 1'b0;
    check("rml_wait", {31'd0, mem_rdata_ready}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; mem_rdata_valid = 1'b1; mem_rdata = 32'h99999999;
    check("rml_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("rml_wen", {31'd0, rf_wen}, 32'd0);
    check("rml_done", {31'd0, wb_done}, 32'd0);
    check("rml_wdata", rf_wdata, 32'd0);
    step();
    mem_rdata_valid = 1'b0;
    check("rml_done2", {31'd0, wb_done}, 32'd0);
    check("rml_idle", {31'd0, in_ready}, 32'd1);

`ifdef WB_PERF_CNT_EN
    // Three ALU retirements after the reset above.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_is_load = 1'b0; in_rd = 5'd1; in_result = k;
      step();
      in_valid = 1'b0;
      step();
    end
    check("perf_retired", retired_cnt, 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("perf_ret_rst", retired_cnt, 32'd0);
    check("perf_stall_rst", load_stall_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
